// File: rtl/dma_read_sequencer.sv
// dma_read_sequencer: turns a (src_addr, len_bytes) request into fixed-length INCR bursts
// on a packed AR channel with bounded outstanding bursts. Optional macro: DMA_READ_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start; stray R beats are accepted and dropped
// ISSUE | issuing bursts, at most MAX_OUTSTANDING in flight
// DRAIN | every burst issued, waiting for the final RLAST
// DONE  | one-cycle completion pulse

module dma_read_sequencer #(
  parameter int BEAT_BYTES      = 8,
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] len_bytes,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [32:0] ARADDR,
  input  logic        ARADDR_ready,
  output logic [3:0]  ARLEN,
  output logic [1:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  input  logic [64:0] RDATA,
  input  logic        RLAST,
  input  logic [1:0]  RRESP,
  output logic        RDATA_ready,
  output logic [64:0] data_out,
  input  logic        data_out_ready,
  output logic [31:0] perf_cycles
);

  localparam int BURST_BYTES = BEAT_BYTES * BURST_BEATS;
  localparam int BURST_SHIFT = $clog2(BURST_BYTES);
  localparam int BL_W        = 32 - BURST_SHIFT;
  localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W      = $clog2(BURST_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         next_addr_q, next_addr_d;
  logic [BL_W-1:0]     bursts_left_q, bursts_left_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                error_q, error_d;
  logic                ar_valid_q, ar_valid_d;
  logic [31:0]         ar_addr_q, ar_addr_d;

  logic start_ok, bad_param, busy_st, ar_hs, r_hs, r_last_hs, out_inc, out_dec;

  assign busy_st   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign start_ok  = (state_q == S_IDLE) && start;
  assign bad_param = (len_bytes == '0) || (len_bytes[BURST_SHIFT-1:0] != '0)
                   || (src_addr[BURST_SHIFT-1:0] != '0);
  assign ar_hs     = ar_valid_q && ARADDR_ready;
  assign r_hs      = busy_st && RDATA[64] && data_out_ready;
  assign r_last_hs = r_hs && RLAST;
  assign out_inc   = ar_hs;
  // A stray RLAST with nothing in flight must not underflow the count.
  assign out_dec   = r_last_hs && ((outstanding_q != '0) || ar_hs);

  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    next_addr_d   = next_addr_q;
    bursts_left_d = bursts_left_q;
    outstanding_d = outstanding_q;
    beat_cnt_d    = beat_cnt_q;
    error_d       = error_q;
    if (start_ok) begin
      error_d       = bad_param;
      beat_cnt_d    = '0;
      outstanding_d = '0;
      if (!bad_param) begin
        bursts_left_d = len_bytes[31:BURST_SHIFT];
        next_addr_d   = src_addr;
      end
    end else begin
      if (ar_hs) begin
        next_addr_d   = next_addr_q + 32'(BURST_BYTES);
        bursts_left_d = bursts_left_q - 1'b1;
      end
      if (out_inc && !out_dec)      outstanding_d = outstanding_q + 1'b1;
      else if (out_dec && !out_inc) outstanding_d = outstanding_q - 1'b1;
      if (r_hs) begin
        if (RLAST) begin
          if (beat_cnt_q != LAST_BEAT) error_d = 1'b1;
          beat_cnt_d = '0;
        end else begin
          if (beat_cnt_q == LAST_BEAT) error_d = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (RRESP != 2'b00) error_d = 1'b1;
      end
    end
  end

  // The AR slot reloads from next_addr as soon as it is empty or being accepted.
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    if (!ar_valid_q || ARADDR_ready) begin
      ar_valid_d = 1'b0;
      if (((start_ok && !bad_param) || ((state_q == S_ISSUE) && (bursts_left_d != '0)))
          && (outstanding_d < OUT_W'(MAX_OUTSTANDING))) begin
        ar_valid_d = 1'b1;
        ar_addr_d  = next_addr_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = bad_param ? S_DONE : S_ISSUE;
      S_ISSUE: if (bursts_left_d == '0) state_d = (outstanding_d == '0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (outstanding_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      next_addr_q   <= '0;
      bursts_left_q <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      error_q       <= 1'b0;
      ar_valid_q    <= 1'b0;
      ar_addr_q     <= '0;
    end else begin
      next_addr_q   <= next_addr_d;
      bursts_left_q <= bursts_left_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      error_q       <= error_d;
      ar_valid_q    <= ar_valid_d;
      ar_addr_q     <= ar_addr_d;
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    RDATA_ready = 1'b1;
    data_out    = '0;
    case (state_q)
      S_ISSUE, S_DRAIN: begin
        busy        = 1'b1;
        RDATA_ready = data_out_ready;
        data_out    = RDATA;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign error   = error_q;
  assign ARADDR  = {ar_valid_q, ar_addr_q};
  assign ARLEN   = 4'(BURST_BEATS - 1);
  assign ARSIZE  = 2'b11;
  assign ARBURST = 2'b01;

`ifdef DMA_READ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_ok)                      perf_d = '0;
    else if (busy_st && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: doc/dma_read_sequencer.md
# dma_read_sequencer

Sequences burst reads for the accelerator datapath over the MAXI0 read channels. A start pulse carrying a source address and byte length becomes a stream of fixed-length INCR bursts on the packed AR channel, with at most MAX_OUTSTANDING bursts in flight. Returned beats pass with zero latency to the datapath input stream. The block sits between the config register block (start/src/len) and the `Top` datapath's input port, and reports done/error back for the IRQ.

## Interface
- BEAT_BYTES, 8, bytes per R beat (64-bit bus); fixed.
- BURST_BEATS, 16, beats per burst; ARLEN = BURST_BEATS-1.
- MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts; power of two, ≤ 8.

- CLK  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  byte address of first beat.
- len_bytes  in  32  total bytes to read.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky; cleared by the next accepted start.
- ARADDR  out  33  bit 32 = valid, [31:0] = burst address.
- ARADDR_ready  in  1  AR handshake ready.
- ARLEN  out  4  constant BURST_BEATS-1.
- ARSIZE  out  2  constant 2'b11.
- ARBURST  out  2  constant 2'b01 (INCR).
- RDATA  in  65  bit 64 = valid, [63:0] = beat data.
- RLAST  in  1  last beat of burst.
- RRESP  in  2  beat response.
- RDATA_ready  out  1  R handshake ready.
- data_out  out  65  bit 64 = valid, [63:0] = data to datapath.
- data_out_ready  in  1  datapath ready.
- perf_cycles  out  32  busy-cycle count (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches src_addr/len_bytes and clears error.
  - If len_bytes==0, len_bytes not a multiple of BURST_BEATS*BEAT_BYTES (128), or src_addr not 128-aligned: set error, go to DONE, issue nothing.
  - Otherwise bursts_left = len_bytes>>7, next_addr = src_addr, go to ISSUE.
- ISSUE: ARADDR valid = (bursts_left≠0) && (outstanding<MAX_OUTSTANDING). On handshake: next_addr += 128 (32-bit wrap, no error), bursts_left−1, outstanding+1. When bursts_left reaches 0, go to DRAIN.
- DRAIN: when outstanding==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- R path, busy states: data_out = {RDATA[64], RDATA[63:0]}; RDATA_ready = data_out_ready (combinational).
- R path, IDLE/DONE: RDATA_ready=1 and data_out valid=0. Stale beats after reset are discarded.
- Beat counter (4 bits) counts accepted beats per burst. An RLAST mismatch (RLAST on a non-final beat, or missing on beat BURST_BEATS-1) sets error; the counter resyncs on RLAST.
- RRESP≠0 on any accepted beat sets error. The transfer still drains to completion.
- Accepted beat with RLAST decrements outstanding. If an AR accept and an RLAST accept occur in the same cycle, outstanding is unchanged.
- start while busy: ignored.

## Timing
- Reset values: ARADDR=0, busy=0, done=0, error=0, data_out valid=0, RDATA_ready=1, perf_cycles=0, state IDLE, outstanding=0.
- ARADDR is registered. First valid appears the cycle after start is accepted. Address and valid hold stable while valid && !ARADDR_ready.
- Data path latency is 0 cycles (combinational pass-through).
- done pulses exactly one cycle after the handshake of the final RLAST beat. busy falls in the same cycle done rises.
- Error path for bad parameters: done pulses 1 cycle after start, with error=1.
- Reset mid-operation: returns to IDLE the next cycle, outputs at reset values, counters cleared. In-flight beats are flushed by IDLE's RDATA_ready=1.

## Configuration
- DMA_READ_PERF_EN defined: perf_cycles increments every busy cycle (saturates at 2^32−1) and clears on accepted start.
- DMA_READ_PERF_EN undefined: no counter logic; perf_cycles is tied to 0.

## Test plan
- Single burst: start, src=0x1000_0000, len=128, ARADDR_ready=1, 16 beats with RLAST on the 16th -> exactly one AR at 0x1000_0000 with ARLEN=15; 16 data_out beats; done one cycle after the last beat; error=0.
- Outstanding limit: len=1024 (8 bursts), R held off -> exactly 4 ARs accepted (addresses +0x80 apart), ARADDR valid then low. After one burst completes the 5th AR issues; the 8th AR has address src+0x380.
- Backpressure: data_out_ready toggled 1/0 each cycle -> RDATA_ready mirrors it; no beat lost or duplicated; ARADDR stable under ARADDR_ready=0 stalls.
- Bad parameters: len=100, and separately src=0x1000_0040 -> no AR issued; error=1 and done pulse one cycle after start.
- Response error: RRESP=2'b10 on beat 3 of burst 1 of 2 -> all 32 beats forwarded; done pulses; error=1 until next start.
- Reset mid-drain: reset with 2 bursts outstanding -> next cycle IDLE, busy=0, RDATA_ready=1; stale beats dropped; a following len=128 transfer completes correctly (with DMA_READ_PERF_EN, perf_cycles reads 0 after reset).
